// File: rtl/rlbp_rx_pkg.sv
// rtl/rlbp_rx_pkg.sv - shared types and register map for the LBP code receiver
package rlbp_rx_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_CHECK  = 2'd2,
      S_PARITY = 2'd3
   } rx_state_e;

   localparam logic [3:0] DATA_OFS   = 4'h0;
   localparam logic [3:0] STATUS_OFS = 4'h4;
   localparam logic [3:0] CTRL_OFS   = 4'h8;
   localparam logic [3:0] CNT_OFS    = 4'hC;

   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_LVL_LSB   = 2;
   localparam int STAT_LVL_MSB   = 4;
   localparam int STAT_OVF_BIT   = 5;
   localparam int STAT_FERR_BIT  = 6;
   localparam int STAT_PERR_BIT  = 7;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_IRQEN_BIT = 1;
   localparam int CTRL_CLR_BIT   = 2;

endpackage

// File: rtl/rlbp_code_receiver_if.sv
// rtl/rlbp_code_receiver_if.sv - Wishbone slave bundle for the LBP code receiver
interface rlbp_code_receiver_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o
   );
endinterface

// File: rtl/rlbp_rx_fifo.sv
// rtl/rlbp_rx_fifo.sv - synchronous word FIFO; a push while full is accepted only alongside a pop
module rlbp_rx_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == LW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push_ok && !pop_ok) count_d = count_q + LW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - LW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/rlbp_code_receiver.sv
// rtl/rlbp_code_receiver.sv - serial LBP frame receiver with Wishbone FIFO readout
// Optional even-parity bit per frame when RLBP_RX_PARITY_EN is defined.
module rlbp_code_receiver
   import rlbp_rx_pkg::*;
#(
   parameter int          CODE_W     = 12,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       ser_clk_i,
   input  logic                       ser_start_i,
   input  logic                       ser_data_i,
   input  logic                       ser_done_i,
   rlbp_code_receiver_if.slave        wb,
   output logic                       irq_o
);

   localparam int CNT_W = $clog2(CODE_W + 1);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   // {clk, start, data, done} share one synchroniser so they stay aligned
   logic [3:0] sync1_q, sync2_q;
   logic       ser_clk_prev_q;
   logic       strobe, s_start, s_data, s_done;

   rx_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CODE_W-1:0]  shift_q, shift_d;
   logic               good_frame, ferr_set, perr_set;
`ifdef RLBP_RX_PARITY_EN
   logic               par_ok_q, par_ok_d;
`endif

   logic               enable_q, irq_en_q, ovf_q, ferr_q, perr_q, irq_q;
   logic [15:0]        frame_cnt_q;
   logic               ack_q;
   logic [31:0]        dat_q;

   logic               fifo_pop, fifo_full, fifo_empty;
   logic [CODE_W-1:0]  fifo_rdata;
   logic [LVL_W-1:0]   fifo_level;
   logic [2:0]         lvl3;

   logic               access, hit, rd, wr, clr;
   logic [3:0]         ofs;
   logic [31:0]        rdata;
   logic               unused_ok;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1_q        <= '0;
         sync2_q        <= '0;
         ser_clk_prev_q <= 1'b0;
      end else begin
         sync1_q        <= {ser_clk_i, ser_start_i, ser_data_i, ser_done_i};
         sync2_q        <= sync1_q;
         ser_clk_prev_q <= sync2_q[3];
      end
   end

   assign strobe  = sync2_q[3] & ~ser_clk_prev_q;
   assign s_start = sync2_q[2];
   assign s_data  = sync2_q[1];
   assign s_done  = sync2_q[0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      good_frame = 1'b0;
      ferr_set   = 1'b0;
      perr_set   = 1'b0;
`ifdef RLBP_RX_PARITY_EN
      par_ok_d   = par_ok_q;
`endif
      if (!enable_q) begin
         state_d = S_IDLE;
      end else if (strobe) begin
         case (state_q)
            S_IDLE: begin
               if (s_start) begin
                  state_d = S_SHIFT;
                  cnt_d   = '0;
               end
            end
            S_SHIFT: begin
               if (s_start) begin
                  ferr_set = 1'b1;
                  cnt_d    = '0;
               end else begin
                  shift_d = {shift_q[CODE_W-2:0], s_data};
                  cnt_d   = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(CODE_W - 1)) begin
`ifdef RLBP_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_CHECK;
`endif
                  end
               end
            end
`ifdef RLBP_RX_PARITY_EN
            S_PARITY: begin
               if (s_start) begin
                  ferr_set = 1'b1;
                  cnt_d    = '0;
                  state_d  = S_SHIFT;
               end else begin
                  state_d  = S_CHECK;
                  par_ok_d = ((^shift_q) == s_data);
                  perr_set = ((^shift_q) != s_data);
               end
            end
`endif
            S_CHECK: begin
               if (s_done) good_frame = 1'b1;
               else        ferr_set   = 1'b1;
               cnt_d   = '0;
               state_d = s_start ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
`ifdef RLBP_RX_PARITY_EN
         par_ok_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
`ifdef RLBP_RX_PARITY_EN
         par_ok_q <= par_ok_d;
`endif
      end
   end

   logic fifo_push;
`ifdef RLBP_RX_PARITY_EN
   assign fifo_push = good_frame & par_ok_q;
`else
   assign fifo_push = good_frame;
`endif

   rlbp_rx_fifo #(
      .W     (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (fifo_push),
      .wdata_i (shift_q),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // The cycle after an ack is never a fresh access, even if stb is still high
   assign access   = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
   assign hit      = access & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign ofs      = wb.wbs_adr_i[3:0];
   assign rd       = hit & ~wb.wbs_we_i;
   assign wr       = hit & wb.wbs_we_i;
   assign clr      = wr & (ofs == CTRL_OFS) & wb.wbs_dat_i[CTRL_CLR_BIT];
   assign fifo_pop = rd & (ofs == DATA_OFS);
   assign lvl3     = 3'(fifo_level);

   always_comb begin
      rdata = '0;
      case (ofs)
         DATA_OFS:   rdata = fifo_empty ? 32'd0 : 32'(fifo_rdata);
         STATUS_OFS: begin
            rdata[STAT_EMPTY_BIT]             = fifo_empty;
            rdata[STAT_FULL_BIT]              = fifo_full;
            rdata[STAT_LVL_MSB:STAT_LVL_LSB]  = lvl3;
            rdata[STAT_OVF_BIT]               = ovf_q;
            rdata[STAT_FERR_BIT]              = ferr_q;
            rdata[STAT_PERR_BIT]              = perr_q;
         end
         CTRL_OFS: begin
            rdata[CTRL_EN_BIT]    = enable_q;
            rdata[CTRL_IRQEN_BIT] = irq_en_q;
         end
         CNT_OFS:    rdata = {16'd0, frame_cnt_q};
         default:    rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q       <= 1'b0;
         dat_q       <= '0;
         enable_q    <= 1'b0;
         irq_en_q    <= 1'b0;
         ovf_q       <= 1'b0;
         ferr_q      <= 1'b0;
         perr_q      <= 1'b0;
         frame_cnt_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         ack_q <= hit;
         dat_q <= rd ? rdata : 32'd0;
         if (wr && ofs == CTRL_OFS) begin
            enable_q <= wb.wbs_dat_i[CTRL_EN_BIT];
            irq_en_q <= wb.wbs_dat_i[CTRL_IRQEN_BIT];
         end
         // A new event in the same cycle as a clear keeps the flag set
         ovf_q  <= (ovf_q & ~clr) | (fifo_push & fifo_full & ~fifo_pop);
         ferr_q <= (ferr_q & ~clr) | ferr_set;
`ifdef RLBP_RX_PARITY_EN
         perr_q <= (perr_q & ~clr) | perr_set;
`else
         perr_q <= 1'b0;
`endif
         if (wr && ofs == CNT_OFS) frame_cnt_q <= '0;
         else if (good_frame)      frame_cnt_q <= frame_cnt_q + 16'd1;
         irq_q <= irq_en_q & ~fifo_empty;
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;
   assign irq_o        = irq_q;
   assign unused_ok    = ^{wb.wbs_sel_i, wb.wbs_dat_i[31:3], perr_set};

endmodule
